// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - two-requester word request/response bus for ram_port_arbiter
interface ram_port_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [1:0]         req_we;
    logic [2*AW-1:0]    req_addr;
    logic [2*WIDTH-1:0] req_wdata;
    logic [1:0]         rsp_valid;
    logic [WIDTH-1:0]   rsp_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - single-port RAM shared by two requesters (RAM_ARB_FIXED_PRIO_EN: fixed priority to requester 0)
module ram_port_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    ram_port_arbiter_if.slave  bus,
    output logic               init_done
);
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

    state_t           state, state_nxt;
    logic [AW-1:0]    wcnt;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             gnt_any;
    logic             gnt_idx;
    logic [1:0]       ready;
    logic [AW-1:0]    sel_addr;
    logic [WIDTH-1:0] sel_wdata;
    logic             sel_we;
    logic             sel_in_range;
    logic [1:0]       rsp_valid_q;
    logic [WIDTH-1:0] rsp_data_q;

`ifndef RAM_ARB_FIXED_PRIO_EN
    logic             rr_last;
`endif

    // Next state and the single grant for this cycle
    always_comb begin
        state_nxt = state;
        gnt_any   = 1'b0;
        gnt_idx   = 1'b0;
        case (state)
            ST_INIT: begin
                if (wcnt == LAST) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (bus.req_valid == 2'b11) begin
                    gnt_any = 1'b1;
`ifdef RAM_ARB_FIXED_PRIO_EN
                    gnt_idx = 1'b0;
`else
                    gnt_idx = ~rr_last;
`endif
                end else if (bus.req_valid[0]) begin
                    gnt_any = 1'b1;
                    gnt_idx = 1'b0;
                end else if (bus.req_valid[1]) begin
                    gnt_any = 1'b1;
                    gnt_idx = 1'b1;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
        ready = gnt_any ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
    end

    // Route the granted requester's command to the RAM port
    always_comb begin
        sel_addr     = gnt_idx ? bus.req_addr[2*AW-1:AW] : bus.req_addr[AW-1:0];
        sel_wdata    = gnt_idx ? bus.req_wdata[2*WIDTH-1:WIDTH] : bus.req_wdata[WIDTH-1:0];
        sel_we       = bus.req_we[gnt_idx];
        sel_in_range = ({1'b0, sel_addr} < DEPTH_W);
    end

    // Control state, arbitration history and registered read response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_INIT;
            wcnt        <= '0;
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
            rr_last     <= 1'b1;
`endif
        end else begin
            state <= state_nxt;
            if (state == ST_INIT && wcnt != LAST) wcnt <= wcnt + 1'b1;
            rsp_valid_q <= 2'b00;
            if (gnt_any) begin
`ifndef RAM_ARB_FIXED_PRIO_EN
                rr_last <= gnt_idx;
`endif
                if (!sel_we) begin
                    rsp_valid_q <= ready;
                    rsp_data_q  <= sel_in_range ? mem[sel_addr] : '0;
                end
            end
        end
    end

    // RAM write port: zero-fill during INIT, granted in-range writes in RUN
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[wcnt] <= '0;
        end else if (gnt_any && sel_we && sel_in_range) begin
            mem[sel_addr] <= sel_wdata;
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign init_done     = (state == ST_RUN);
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench for ram_port_arbiter
module tb_ram_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic done_a, done_b;

    always #5 clk = ~clk;

    ram_port_arbiter_if #(.WIDTH(8), .AW(2)) ifa ();
    ram_port_arbiter_if #(.WIDTH(8), .AW(3)) ifb ();

    ram_port_arbiter #(.WIDTH(8), .DEPTH(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa), .init_done(done_a));
    ram_port_arbiter #(.WIDTH(8), .DEPTH(5)) dut_b (.clk(clk), .rst(rst), .bus(ifb), .init_done(done_b));

    typedef struct {
        int idx;
        int data;
        int due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   model_a [4];
    int   model_b [5];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare each response against the front of the expected queue
    always @(negedge clk) begin
        if (qa.size() > 0 && qa[0].due == cyc) begin
            chk("rsp_valid_a", {30'd0, ifa.rsp_valid}, 32'(1 << qa[0].idx));
            chk("rsp_data_a", {24'd0, ifa.rsp_data}, 32'(qa[0].data));
            void'(qa.pop_front());
        end else if (ifa.rsp_valid !== 2'b00) begin
            chk("unexpected_rsp_a", {30'd0, ifa.rsp_valid}, 32'd0);
        end
        if (qb.size() > 0 && qb[0].due == cyc) begin
            chk("rsp_valid_b", {30'd0, ifb.rsp_valid}, 32'(1 << qb[0].idx));
            chk("rsp_data_b", {24'd0, ifb.rsp_data}, 32'(qb[0].data));
            void'(qb.pop_front());
        end else if (ifb.rsp_valid !== 2'b00) begin
            chk("unexpected_rsp_b", {30'd0, ifb.rsp_valid}, 32'd0);
        end
    end

    // Issue one request from requester i on DUT a (b=0) or b (b=1), wait for accept
    task automatic req(input bit b, input int i, input bit we, input int addr, input int data);
        int  n = 0;
        bit  acc = 1'b0;
        if (!b) begin
            ifa.req_valid = 2'(1 << i);
            ifa.req_we    = we ? 2'(1 << i) : 2'b00;
            ifa.req_addr  = (i == 1) ? {2'(addr), 2'd0} : {2'd0, 2'(addr)};
            ifa.req_wdata = (i == 1) ? {8'(data), 8'd0} : {8'd0, 8'(data)};
        end else begin
            ifb.req_valid = 2'(1 << i);
            ifb.req_we    = we ? 2'(1 << i) : 2'b00;
            ifb.req_addr  = (i == 1) ? {3'(addr), 3'd0} : {3'd0, 3'(addr)};
            ifb.req_wdata = (i == 1) ? {8'(data), 8'd0} : {8'd0, 8'(data)};
        end
        while (!acc) begin
            @(negedge clk);
            acc = b ? (ifb.req_ready[i] === 1'b1) : (ifa.req_ready[i] === 1'b1);
            if (!acc && ++n >= 20) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        if (acc) begin
            if (!b) begin
                if (we) begin
                    if (addr < 4) model_a[addr] = data;
                end else begin
                    qa.push_back('{i, (addr < 4) ? model_a[addr] : 0, cyc + 1});
                end
            end else begin
                if (we) begin
                    if (addr < 5) model_b[addr] = data;
                end else begin
                    qb.push_back('{i, (addr < 5) ? model_b[addr] : 0, cyc + 1});
                end
            end
        end
        @(posedge clk);
        #1;
        ifa.req_valid = 2'b00;
        ifb.req_valid = 2'b00;
    endtask

    initial begin
        logic [1:0] r;
        int         n;
        rst = 1'b1;
        ifa.req_valid = 2'b00; ifa.req_we = 2'b00; ifa.req_addr = '0; ifa.req_wdata = '0;
        ifb.req_valid = 2'b00; ifb.req_we = 2'b00; ifb.req_addr = '0; ifb.req_wdata = '0;
        foreach (model_a[k]) model_a[k] = 0;
        foreach (model_b[k]) model_b[k] = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", {30'd0, ifa.req_ready}, 32'd0);
        chk("reset_rsp_valid", {30'd0, ifa.rsp_valid}, 32'd0);
        chk("reset_rsp_data", {24'd0, ifa.rsp_data}, 32'd0);
        chk("reset_init_done", {31'd0, done_a}, 32'd0);

        // Zero-fill window: DEPTH cycles with no grants
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ifa.req_valid = 2'b11;
            @(negedge clk);
            chk("init_done_low", {31'd0, done_a}, 32'd0);
            chk("init_ready_low", {30'd0, ifa.req_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        ifa.req_valid = 2'b00;
        @(negedge clk);
        chk("init_done_high", {31'd0, done_a}, 32'd1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) req(1'b0, 1, 1'b0, k, 0);

        // Write then immediate read of the same address
        req(1'b0, 0, 1'b1, 2, 8'hA5);
        req(1'b0, 1, 1'b0, 2, 0);

        // Both requesters valid for 4 cycles: req0 writes addr3, req1 reads addr3
        ifa.req_valid = 2'b11;
        ifa.req_we    = 2'b01;
        ifa.req_addr  = {2'd3, 2'd3};
        ifa.req_wdata = {8'd0, 8'h11};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            r = ifa.req_ready;
`ifdef RAM_ARB_FIXED_PRIO_EN
            chk("tie_grant", {30'd0, r}, 32'd1);
`else
            chk("tie_grant", {30'd0, r}, (k % 2 == 0) ? 32'd1 : 32'd2);
`endif
            if (r == 2'b01) model_a[3] = 8'h11;
            if (r == 2'b10) qa.push_back('{1, model_a[3], cyc + 1});
            @(posedge clk);
            #1;
        end
        ifa.req_valid = 2'b00;

        // Out-of-range accesses on the DEPTH=5 instance
        chk("init_done_b", {31'd0, done_b}, 32'd1);
        req(1'b1, 0, 1'b1, 4, 8'h44);
        req(1'b1, 1, 1'b0, 5, 0);
        req(1'b1, 0, 1'b1, 6, 8'hFF);
        for (int k = 0; k < 5; k++) req(1'b1, 1, 1'b0, k, 0);

        // Reset right after a read accept, then verify re-zeroing
        req(1'b0, 0, 1'b1, 1, 8'h3C);
        req(1'b0, 1, 1'b0, 1, 0);
        rst = 1'b1;
        qa.delete();
        qb.delete();
        foreach (model_a[k]) model_a[k] = 0;
        foreach (model_b[k]) model_b[k] = 0;
        #1;
        chk("rst_rsp_valid", {30'd0, ifa.rsp_valid}, 32'd0);
        chk("rst_init_done", {31'd0, done_a}, 32'd0);
        @(negedge clk);
        chk("rst_rsp_valid_hold", {30'd0, ifa.rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        while (done_a !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reinit_done", {31'd0, done_a}, 32'd1);
        req(1'b0, 1, 1'b0, 1, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_a_empty", 32'(qa.size()), 32'd0);
        chk("queue_b_empty", 32'(qb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
